// File: rtl/shift_datapath.sv
// Datapath for the Maquina_Estados control FSM: serial-in PR, shift-out SR,
// primary bit counter and frame counter. Optional parity output via `PARITY_EN.
module shift_datapath #(
    parameter int WIDTH        = 8,
    parameter int FRAME_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Din,
    input  logic             Shift_PR,
    input  logic             EPC,
    input  logic             Shift_SR,
    input  logic             EFC,
    output logic             ESR,
    output logic             FCE,
    output logic             Dout,
    output logic [WIDTH-1:0] Word_Out,
    output logic             Par_Out
);

    localparam int PW = $clog2(WIDTH + 1);
    localparam int FW = $clog2(FRAME_CYCLES);
    localparam logic [PW-1:0] PMAX = PW'(WIDTH);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [FW-1:0] FMAX = FW'(FRAME_CYCLES - 1);
    localparam logic [FW-1:0] FONE = FW'(1);

    logic [WIDTH-1:0] pr_q, pr_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             esr_q, esr_d;
    logic             transfer;

    // The transfer edge outranks every other strobe: it loads SR and clears the primary side.
    always_comb begin
        transfer = EFC && esr_q;

        pr_d = pr_q;
        if (!transfer && Shift_PR)
            pr_d = {pr_q[WIDTH-2:0], Din};

        pcnt_d = pcnt_q;
        if (transfer)
            pcnt_d = '0;
        else if (EPC && (pcnt_q != PMAX))
            pcnt_d = pcnt_q + PONE;

        esr_d = !transfer && (pcnt_d == PMAX);

        sr_d = sr_q;
        if (transfer)
            sr_d = pr_q;
        else if (Shift_SR)
            sr_d = {sr_q[WIDTH-2:0], 1'b0};

        fcnt_d = '0;
        if (EFC)
            fcnt_d = (fcnt_q == FMAX) ? fcnt_q : fcnt_q + FONE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pr_q   <= '0;
            sr_q   <= '0;
            pcnt_q <= '0;
            fcnt_q <= '0;
            esr_q  <= 1'b0;
        end else begin
            pr_q   <= pr_d;
            sr_q   <= sr_d;
            pcnt_q <= pcnt_d;
            fcnt_q <= fcnt_d;
            esr_q  <= esr_d;
        end
    end

`ifdef PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (transfer)
            par_d = ^pr_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end

    assign Par_Out = par_q;
`else
    assign Par_Out = 1'b0;
`endif

    assign ESR      = esr_q;
    assign FCE      = EFC && (fcnt_q == FMAX);
    assign Dout     = sr_q[WIDTH-1];
    assign Word_Out = sr_q;

endmodule

// File: tb/tb_shift_datapath.sv
// Directed bench for shift_datapath (WIDTH=8, FRAME_CYCLES=16): vector table
// plus hand-written reset and frame-counter sequences.
module tb_shift_datapath;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Din = 1'b0, Shift_PR = 1'b0, EPC = 1'b0, Shift_SR = 1'b0, EFC = 1'b0;
    logic       ESR, FCE, Dout, Par_Out;
    logic [7:0] Word_Out;

    int total = 0;
    int bad   = 0;

`ifdef PARITY_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    shift_datapath #(.WIDTH(8), .FRAME_CYCLES(16)) dut (
        .Clk(Clk), .Reset(Reset), .Din(Din), .Shift_PR(Shift_PR), .EPC(EPC),
        .Shift_SR(Shift_SR), .EFC(EFC), .ESR(ESR), .FCE(FCE), .Dout(Dout),
        .Word_Out(Word_Out), .Par_Out(Par_Out)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0] in;    // {Din, Shift_PR, EPC, Shift_SR, EFC}
        logic       esr;
        logic [7:0] word;
        logic       par;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [4:0] in, input logic esr, input logic [7:0] word, input logic par);
        vec_t v;
        v.in = in; v.esr = esr; v.word = word; v.par = par;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {Din, Shift_PR, EPC, Shift_SR, EFC} = in;
    endtask

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        drive(5'b0);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        edge1();
    endtask

    initial begin
        // Shift A5 MSB-first with Shift_PR and EPC
        add(5'b11100, 0, 8'h00, 0); add(5'b01100, 0, 8'h00, 0);
        add(5'b11100, 0, 8'h00, 0); add(5'b01100, 0, 8'h00, 0);
        add(5'b01100, 0, 8'h00, 0); add(5'b11100, 0, 8'h00, 0);
        add(5'b01100, 0, 8'h00, 0); add(5'b11100, 1, 8'h00, 0);
        add(5'b00001, 0, 8'hA5, 0);                                 // transfer
        add(5'b00010, 0, 8'h4A, 0);                                 // one SR shift
        // Load 81 into PR while SR keeps shifting
        add(5'b11110, 0, 8'h94, 0); add(5'b01110, 0, 8'h28, 0);
        add(5'b01110, 0, 8'h50, 0); add(5'b01110, 0, 8'hA0, 0);
        add(5'b01110, 0, 8'h40, 0); add(5'b01110, 0, 8'h80, 0);
        add(5'b01110, 0, 8'h00, 0); add(5'b11110, 1, 8'h00, 0);
        add(5'b11111, 0, 8'h81, 0);                                 // transfer beats every strobe
        // Eight SR shifts with EPC: ESR must need all eight strobes again
        add(5'b00110, 0, 8'h02, 0); add(5'b00110, 0, 8'h04, 0);
        add(5'b00110, 0, 8'h08, 0); add(5'b00110, 0, 8'h10, 0);
        add(5'b00110, 0, 8'h20, 0); add(5'b00110, 0, 8'h40, 0);
        add(5'b00110, 0, 8'h80, 0); add(5'b00110, 1, 8'h00, 0);
        add(5'b00001, 0, 8'h81, 0);                                 // PR was untouched by transfer edge
        // Load 07, then over-run the bit counter
        add(5'b01100, 0, 8'h81, 0); add(5'b01100, 0, 8'h81, 0);
        add(5'b01100, 0, 8'h81, 0); add(5'b01100, 0, 8'h81, 0);
        add(5'b01100, 0, 8'h81, 0); add(5'b11100, 0, 8'h81, 0);
        add(5'b11100, 0, 8'h81, 0); add(5'b11100, 1, 8'h81, 0);
        for (int k = 0; k < 10; k++) add(5'b00100, 1, 8'h81, 0);
        add(5'b00001, 0, 8'h07, PE);
        add(5'b00011, 0, 8'h0E, PE);                                // EFC held, ESR=0: plain shift

        do_reset();
        chk("rst_esr",  0, 32'(ESR),      32'd0);
        chk("rst_fce",  0, 32'(FCE),      32'd0);
        chk("rst_dout", 0, 32'(Dout),     32'd0);
        chk("rst_word", 0, 32'(Word_Out), 32'd0);
        chk("rst_par",  0, 32'(Par_Out),  32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].in);
            edge1();
            chk("esr",  i, 32'(ESR),      32'(vq[i].esr));
            chk("fce",  i, 32'(FCE),      32'd0);
            chk("dout", i, 32'(Dout),     32'(vq[i].word[7]));
            chk("word", i, 32'(Word_Out), 32'(vq[i].word));
            chk("par",  i, 32'(Par_Out),  32'(vq[i].par));
        end

        // Frame counter: FCE after the 15th edge, holds, drops with EFC
        do_reset();
        drive(5'b00001);
        for (int c = 1; c <= 20; c++) begin
            edge1();
            chk("fce_run", c, 32'(FCE), (c >= 15) ? 32'd1 : 32'd0);
        end
        EFC = 1'b0;
        #1;
        chk("fce_drop", 0, 32'(FCE), 32'd0);
        edge1();
        EFC = 1'b1;
        #1;
        chk("fce_clr", 0, 32'(FCE), 32'd0);
        for (int c = 1; c <= 15; c++) edge1();
        chk("fce_again", 0, 32'(FCE), 32'd1);

        // Asynchronous reset mid-frame with PR=FF, ESR=1, Word=FF
        do_reset();
        for (int c = 0; c < 8; c++) begin drive(5'b11100); edge1(); end
        drive(5'b00001); edge1();
        chk("ff_word", 0, 32'(Word_Out), 32'hFF);
        for (int c = 0; c < 8; c++) begin drive(5'b11101); edge1(); end
        chk("ff_esr", 0, 32'(ESR), 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        chk("arst_esr",  0, 32'(ESR),      32'd0);
        chk("arst_fce",  0, 32'(FCE),      32'd0);
        chk("arst_word", 0, 32'(Word_Out), 32'd0);
        chk("arst_dout", 0, 32'(Dout),     32'd0);
        chk("arst_par",  0, 32'(Par_Out),  32'd0);
        drive(5'b0);
        @(negedge Clk);
        Reset = 1'b1;
        edge1();
        chk("post_esr", 0, 32'(ESR), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
